// File: rtl/pipe_ctrl_pkg.sv
// Purpose: shared encodings, opcode constants and the control bundle for the pipelined control unit.
// Latency: none (types, constants and pure helper functions only).
// Backpressure: n/a.
package ctrl_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLT  = 4'd5,
        ALU_SLTU = 4'd6,
        ALU_SLL  = 4'd7,
        ALU_SRL  = 4'd8,
        ALU_SRA  = 4'd9,
        ALU_BSEL = 4'd10
    } alu_op_e;

    localparam logic [2:0] IMM_I = 3'd0;
    localparam logic [2:0] IMM_S = 3'd1;
    localparam logic [2:0] IMM_B = 3'd2;
    localparam logic [2:0] IMM_U = 3'd3;
    localparam logic [2:0] IMM_J = 3'd4;

    localparam logic [1:0] WB_MEM = 2'd0;
    localparam logic [1:0] WB_ALU = 2'd1;
    localparam logic [1:0] WB_PC4 = 2'd2;
    localparam logic [1:0] WB_CSR = 2'd3;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    // Control bundle carried D -> X -> W. An all-zero value is a bubble.
    typedef struct packed {
        logic       valid;
        logic [4:0] rd;        // zero unless reg_wen
        logic [4:0] rs1;       // zero unless use_rs1
        logic [4:0] rs2;       // zero unless use_rs2
        logic       use_rs1;
        logic       use_rs2;
        logic [2:0] imm_sel;
        logic       a_sel;
        logic       b_sel;
        alu_op_e    alu_sel;
        logic       br_un;
        logic       mem_wen;
        logic       reg_wen;
        logic [1:0] wb_sel;
        logic       csr_wen;
        logic       is_load;
        logic       is_branch;
        logic       is_jal;
        logic       is_jalr;
        logic [2:0] funct3;
    } ctrl_t;

    // Shared R/I-type ALU mapping; only register ops may select SUB.
    function automatic alu_op_e alu_op(input logic [2:0] f3, input logic b30, input logic is_reg);
        case (f3)
            3'b000:  alu_op = (is_reg && b30) ? ALU_SUB : ALU_ADD;
            3'b001:  alu_op = ALU_SLL;
            3'b010:  alu_op = ALU_SLT;
            3'b011:  alu_op = ALU_SLTU;
            3'b100:  alu_op = ALU_XOR;
            3'b101:  alu_op = b30 ? ALU_SRA : ALU_SRL;
            3'b110:  alu_op = ALU_OR;
            default: alu_op = ALU_AND;
        endcase
    endfunction

    // Does stage s write a register that the decoding instruction d reads?
    function automatic logic raw_hit(input ctrl_t s, input ctrl_t d);
        return s.valid & s.reg_wen & (s.rd != 5'd0) &
               ((d.use_rs1 & (s.rd == d.rs1)) | (d.use_rs2 & (s.rd == d.rs2)));
    endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Purpose: datapath <-> control unit bus (D instruction, branch compare, selects, enables, counters).
// Latency: none (wires only).
// Backpressure: hold freezes the unit; stall_d tells fetch to keep the PC.
// Ports: master = datapath side, slave = pipe_ctrl side.
interface pipe_ctrl_if #(parameter int CNT_W = 64);
    logic [31:0]      inst_d;
    logic             inst_valid_d;
    logic             hold;
    logic             br_eq;
    logic             br_lt;
    logic [2:0]       imm_sel;
    logic             stall_d;
    logic             a_sel;
    logic             b_sel;
    logic [3:0]       alu_sel;
    logic             br_un;
    logic             fwd_a;
    logic             fwd_b;
    logic             mem_wen;
    logic [2:0]       mem_funct3;
    logic             pc_sel;
    logic             flush;
    logic             reg_wen;
    logic [4:0]       wb_rd;
    logic [1:0]       wb_sel;
    logic             csr_wen;
    logic [CNT_W-1:0] cycle_cnt;
    logic [CNT_W-1:0] instret_cnt;

    modport master (
        output inst_d, inst_valid_d, hold, br_eq, br_lt,
        input  imm_sel, stall_d, a_sel, b_sel, alu_sel, br_un, fwd_a, fwd_b,
               mem_wen, mem_funct3, pc_sel, flush, reg_wen, wb_rd, wb_sel,
               csr_wen, cycle_cnt, instret_cnt
    );

    modport slave (
        input  inst_d, inst_valid_d, hold, br_eq, br_lt,
        output imm_sel, stall_d, a_sel, b_sel, alu_sel, br_un, fwd_a, fwd_b,
               mem_wen, mem_funct3, pc_sel, flush, reg_wen, wb_rd, wb_sel,
               csr_wen, cycle_cnt, instret_cnt
    );
endinterface

// File: rtl/pipe_ctrl_decode.sv
// Purpose: RV32I instruction -> control bundle; unsupported encodings become a bubble.
// Latency: combinational.
// Backpressure: none.
// Ports: inst (32-bit instruction), ctrl (decoded bundle).
module inst_decode
    import ctrl_pkg::*;
(
    input  logic [31:0] inst,
    output ctrl_t       ctrl
);

    logic [2:0] f3;
    logic       unused_bits;

    assign f3          = inst[14:12];
    assign unused_bits = ^{inst[31], inst[29:25]};

    always_comb begin
        ctrl = '0;
        case (inst[6:0])
            OP_REG: begin
                ctrl.valid   = 1'b1;
                ctrl.use_rs1 = 1'b1;
                ctrl.use_rs2 = 1'b1;
                ctrl.alu_sel = alu_op(f3, inst[30], 1'b1);
                ctrl.reg_wen = 1'b1;
                ctrl.wb_sel  = WB_ALU;
            end
            OP_IMM: begin
                ctrl.valid   = 1'b1;
                ctrl.use_rs1 = 1'b1;
                ctrl.b_sel   = 1'b1;
                ctrl.alu_sel = alu_op(f3, inst[30], 1'b0);
                ctrl.reg_wen = 1'b1;
                ctrl.wb_sel  = WB_ALU;
            end
            OP_LUI: begin
                // ALU passes operand B straight through, so A is effectively zero.
                ctrl.valid   = 1'b1;
                ctrl.imm_sel = IMM_U;
                ctrl.b_sel   = 1'b1;
                ctrl.alu_sel = ALU_BSEL;
                ctrl.reg_wen = 1'b1;
                ctrl.wb_sel  = WB_ALU;
            end
            OP_AUIPC: begin
                ctrl.valid   = 1'b1;
                ctrl.imm_sel = IMM_U;
                ctrl.a_sel   = 1'b1;
                ctrl.b_sel   = 1'b1;
                ctrl.reg_wen = 1'b1;
                ctrl.wb_sel  = WB_ALU;
            end
            OP_JAL: begin
                ctrl.valid   = 1'b1;
                ctrl.imm_sel = IMM_J;
                ctrl.a_sel   = 1'b1;
                ctrl.b_sel   = 1'b1;
                ctrl.reg_wen = 1'b1;
                ctrl.wb_sel  = WB_PC4;
                ctrl.is_jal  = 1'b1;
            end
            OP_JALR: begin
                ctrl.valid   = 1'b1;
                ctrl.use_rs1 = 1'b1;
                ctrl.b_sel   = 1'b1;
                ctrl.reg_wen = 1'b1;
                ctrl.wb_sel  = WB_PC4;
                ctrl.is_jalr = 1'b1;
            end
            OP_BRANCH: begin
                ctrl.valid     = 1'b1;
                ctrl.use_rs1   = 1'b1;
                ctrl.use_rs2   = 1'b1;
                ctrl.imm_sel   = IMM_B;
                ctrl.a_sel     = 1'b1;
                ctrl.b_sel     = 1'b1;
                ctrl.br_un     = f3[1];   // BLTU/BGEU
                ctrl.is_branch = 1'b1;
            end
            OP_LOAD: begin
                ctrl.valid   = 1'b1;
                ctrl.use_rs1 = 1'b1;
                ctrl.b_sel   = 1'b1;
                ctrl.reg_wen = 1'b1;
                ctrl.wb_sel  = WB_MEM;
                ctrl.is_load = 1'b1;
            end
            OP_STORE: begin
                ctrl.valid   = 1'b1;
                ctrl.use_rs1 = 1'b1;
                ctrl.use_rs2 = 1'b1;
                ctrl.imm_sel = IMM_S;
                ctrl.b_sel   = 1'b1;
                ctrl.mem_wen = 1'b1;
            end
            OP_SYSTEM: begin
                // Only CSRRW (001) and CSRRWI (101); ECALL/EBREAK/others stay a bubble.
                if (f3[1:0] == 2'b01) begin
                    ctrl.valid   = 1'b1;
                    ctrl.use_rs1 = ~f3[2];
                    ctrl.reg_wen = 1'b1;
                    ctrl.wb_sel  = WB_CSR;
                    ctrl.csr_wen = 1'b1;
                end
            end
            default: ctrl = '0;
        endcase
        // Zero unused register fields so hazard/forward compares never see stale bits.
        ctrl.rd     = ctrl.reg_wen ? inst[11:7]  : 5'd0;
        ctrl.rs1    = ctrl.use_rs1 ? inst[19:15] : 5'd0;
        ctrl.rs2    = ctrl.use_rs2 ? inst[24:20] : 5'd0;
        ctrl.funct3 = ctrl.valid   ? f3          : 3'd0;
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Purpose: 3-stage (D/X/W) control: decode, stage registers, branch redirect, forwarding/interlock, perf counters.
// Latency: X outputs 1 cycle after D accept, W outputs 2 cycles; imm_sel/stall_d combinational at D.
// Backpressure: hold freezes both stages and masks pc_sel/flush/mem_wen/stall_d; stall_d holds fetch.
// Ports: clk, rst (async active-high), bus (pipe_ctrl_if.slave).
// Build option: PIPE_CTRL_FWD_EN enables W->X forwarding instead of the D interlock.
module pipe_ctrl
    import ctrl_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 64
) (
    input  logic        clk,
    input  logic        rst,
    pipe_ctrl_if.slave  bus
);

    // XLEN only matters to the datapath-side counter readout.
    localparam int unused_xlen = XLEN;

    ctrl_t            dec;
    ctrl_t            x_q;
    ctrl_t            w_q;
    logic             d_vld;
    logic             br_taken;
    logic             redirect;
    logic             hz_stall;
    logic [CNT_W-1:0] cycle_q;
    logic [CNT_W-1:0] instret_q;
    logic             unused_bits;

    inst_decode u_decode (
        .inst (bus.inst_d),
        .ctrl (dec)
    );

    assign d_vld       = bus.inst_valid_d & dec.valid;
    assign unused_bits = ^{x_q, w_q, dec};

    always_comb begin
        br_taken = 1'b0;
        case (x_q.funct3)
            3'b000:  br_taken =  bus.br_eq;
            3'b001:  br_taken = ~bus.br_eq;
            3'b100,
            3'b110:  br_taken =  bus.br_lt;
            3'b101,
            3'b111:  br_taken = ~bus.br_lt;
            default: br_taken = 1'b0;
        endcase
    end

    assign redirect = x_q.valid & (x_q.is_jal | x_q.is_jalr | (x_q.is_branch & br_taken));

`ifdef PIPE_CTRL_FWD_EN
    assign hz_stall  = 1'b0;
    assign bus.fwd_a = x_q.valid & w_q.valid & w_q.reg_wen & (w_q.rd != 5'd0) & (w_q.rd == x_q.rs1);
    assign bus.fwd_b = x_q.valid & w_q.valid & w_q.reg_wen & (w_q.rd != 5'd0) & (w_q.rd == x_q.rs2);
`else
    // Without forwarding the producer must leave W before the consumer enters X.
    assign hz_stall  = d_vld & (raw_hit(x_q, dec) | raw_hit(w_q, dec));
    assign bus.fwd_a = 1'b0;
    assign bus.fwd_b = 1'b0;
`endif

    // D-side outputs are the only ones not fed from a register, so mask them in reset.
    assign bus.imm_sel    = rst ? 3'd0 : dec.imm_sel;
    assign bus.stall_d    = hz_stall & ~bus.hold & ~rst;

    assign bus.pc_sel     = redirect & ~bus.hold;
    assign bus.flush      = redirect & ~bus.hold;
    assign bus.a_sel      = x_q.valid & x_q.a_sel;
    assign bus.b_sel      = x_q.valid & x_q.b_sel;
    assign bus.alu_sel    = x_q.valid ? x_q.alu_sel : ALU_ADD;
    assign bus.br_un      = x_q.valid & x_q.br_un;
    assign bus.mem_wen    = x_q.valid & x_q.mem_wen & ~bus.hold;
    assign bus.mem_funct3 = (x_q.valid & (x_q.is_load | x_q.mem_wen)) ? x_q.funct3 : 3'd0;

    assign bus.reg_wen    = w_q.valid & w_q.reg_wen;
    assign bus.wb_rd      = w_q.valid ? w_q.rd : 5'd0;
    assign bus.wb_sel     = w_q.valid ? w_q.wb_sel : WB_MEM;
    assign bus.csr_wen    = w_q.valid & w_q.csr_wen;

    assign bus.cycle_cnt   = cycle_q;
    assign bus.instret_cnt = instret_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_q       <= '0;
            w_q       <= '0;
            cycle_q   <= '0;
            instret_q <= '0;
        end else begin
            cycle_q <= cycle_q + 1'b1;
            if (!bus.hold) begin
                // Redirect beats stall: a stalled instruction behind a taken branch is wrong-path.
                x_q       <= (redirect | hz_stall | ~d_vld) ? '0 : dec;
                w_q       <= x_q;
                instret_q <= instret_q + {{(CNT_W-1){1'b0}}, w_q.valid};
            end
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Purpose: directed self-checking bench for pipe_ctrl (decode, hazards, redirect, hold, reset, counters).
// Latency: checks sampled 3 time units after each rising edge.
// Backpressure: exercises hold and stall_d directly.
module tb_pipe_ctrl;

    logic clk;
    logic rst;
    int   tests;
    int   fails;

    localparam logic [31:0] I_ADD   = 32'h003100B3;  // add  x1,x2,x3
    localparam logic [31:0] I_ADDI1 = 32'h00500093;  // addi x1,x0,5
    localparam logic [31:0] I_ADD2  = 32'h00108133;  // add  x2,x1,x1
    localparam logic [31:0] I_ADDI0 = 32'h00100013;  // addi x0,x0,1
    localparam logic [31:0] I_ADD3  = 32'h000001B3;  // add  x3,x0,x0
    localparam logic [31:0] I_ADDI5 = 32'h00100293;  // addi x5,x0,1
    localparam logic [31:0] I_BEQ   = 32'h00000463;  // beq  x0,x0,8
    localparam logic [31:0] I_BNE   = 32'h00001463;  // bne  x0,x0,8
    localparam logic [31:0] I_BLTU  = 32'h0020E463;  // bltu x1,x2,8
    localparam logic [31:0] I_SW    = 32'h0021A023;  // sw   x2,0(x3)
    localparam logic [31:0] I_LUI   = 32'h123450B7;  // lui  x1,0x12345
    localparam logic [31:0] I_CSRRW = 32'h300110F3;  // csrrw x1,0x300,x2
    localparam logic [31:0] I_JAL   = 32'h010000EF;  // jal  x1,16

    pipe_ctrl_if #(.CNT_W(64)) bus ();

    pipe_ctrl #(.XLEN(32), .CNT_W(64)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic drain();
        bus.inst_valid_d = 1'b0;
        bus.hold = 1'b0;
        bus.br_eq = 1'b0;
        bus.br_lt = 1'b0;
        repeat (3) cyc();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.inst_d = 32'h0; bus.inst_valid_d = 1'b0; bus.hold = 1'b0;
        bus.br_eq = 1'b0; bus.br_lt = 1'b0;
        cyc(); cyc(); #1;
        tests++;
        if (bus.cycle_cnt !== 64'd0) begin fails++; $display("FAIL rst_cycle: got %0d exp 0", bus.cycle_cnt); end
        tests++;
        if (bus.instret_cnt !== 64'd0) begin fails++; $display("FAIL rst_instret: got %0d exp 0", bus.instret_cnt); end
        tests++;
        if ({bus.reg_wen, bus.pc_sel, bus.flush, bus.mem_wen, bus.stall_d, bus.wb_rd} !== 10'd0) begin
            fails++; $display("FAIL rst_outs: got %b exp 0", {bus.reg_wen, bus.pc_sel, bus.flush, bus.mem_wen, bus.stall_d, bus.wb_rd});
        end
        rst = 1'b0;
        cyc(); #1;
        tests++;
        if (bus.cycle_cnt !== 64'd1) begin fails++; $display("FAIL rst_release_cycle: got %0d exp 1", bus.cycle_cnt); end
    endtask

    task automatic test_add();
        logic [63:0] i0;
        drain();
        cyc(); bus.inst_d = I_ADD; bus.inst_valid_d = 1'b1; #1;
        cyc(); bus.inst_valid_d = 1'b0; #1;
        tests++;
        if ({bus.alu_sel, bus.a_sel, bus.b_sel} !== 6'b000000) begin
            fails++; $display("FAIL add_x_sel: got %b exp 000000", {bus.alu_sel, bus.a_sel, bus.b_sel});
        end
        i0 = bus.instret_cnt;
        cyc(); #1;
        tests++;
        if ({bus.reg_wen, bus.wb_rd, bus.wb_sel} !== {1'b1, 5'd1, 2'd1}) begin
            fails++; $display("FAIL add_w: got %b exp 1_00001_01", {bus.reg_wen, bus.wb_rd, bus.wb_sel});
        end
        cyc(); #1;
        tests++;
        if (bus.instret_cnt !== i0 + 64'd1) begin fails++; $display("FAIL add_instret: got %0d exp %0d", bus.instret_cnt, i0 + 64'd1); end
    endtask

    task automatic test_decode_table();
        logic [31:0] t_inst [8];
        logic [2:0]  t_imm  [8];
        logic [9:0]  t_x    [8];  // {alu_sel, a_sel, b_sel, mem_wen, mem_funct3}
        t_inst = '{32'h403100B3, 32'h40315093, 32'hC0010093, I_LUI, I_SW, 32'h00000073, 32'h00001217, 32'h003150B3};
        t_imm  = '{3'd0, 3'd0, 3'd0, 3'd3, 3'd1, 3'd0, 3'd3, 3'd0};
        t_x    = '{{4'd1, 3'b000, 3'd0}, {4'd9, 3'b010, 3'd0}, {4'd0, 3'b010, 3'd0}, {4'd10, 3'b010, 3'd0},
                   {4'd0, 3'b011, 3'd2}, {4'd0, 3'b000, 3'd0}, {4'd0, 3'b110, 3'd0}, {4'd8, 3'b000, 3'd0}};
        drain();
        for (int i = 0; i <= 8; i++) begin
            cyc();
            if (i < 8) begin bus.inst_d = t_inst[i]; bus.inst_valid_d = 1'b1; end
            else bus.inst_valid_d = 1'b0;
            #1;
            if (i < 8) begin
                tests++;
                if (bus.imm_sel !== t_imm[i]) begin fails++; $display("FAIL dec_imm[%0d]: got %0d exp %0d", i, bus.imm_sel, t_imm[i]); end
            end
            if (i > 0) begin
                tests++;
                if ({bus.alu_sel, bus.a_sel, bus.b_sel, bus.mem_wen, bus.mem_funct3} !== t_x[i-1]) begin
                    fails++; $display("FAIL dec_x[%0d]: got %b exp %b", i - 1,
                        {bus.alu_sel, bus.a_sel, bus.b_sel, bus.mem_wen, bus.mem_funct3}, t_x[i-1]);
                end
            end
        end
    endtask

    task automatic test_raw_hazard();
        drain();
        cyc(); bus.inst_d = I_ADDI1; bus.inst_valid_d = 1'b1; #1;
        tests++;
        if (bus.stall_d !== 1'b0) begin fails++; $display("FAIL raw_first_stall: got %b exp 0", bus.stall_d); end
        cyc(); bus.inst_d = I_ADD2; #1;
`ifdef PIPE_CTRL_FWD_EN
        tests++;
        if (bus.stall_d !== 1'b0) begin fails++; $display("FAIL fwd_stall: got %b exp 0", bus.stall_d); end
        cyc(); bus.inst_valid_d = 1'b0; #1;
        tests++;
        if ({bus.fwd_a, bus.fwd_b} !== 2'b11) begin fails++; $display("FAIL fwd_ab: got %b exp 11", {bus.fwd_a, bus.fwd_b}); end
`else
        tests++;
        if (bus.stall_d !== 1'b1) begin fails++; $display("FAIL stall_c1: got %b exp 1", bus.stall_d); end
        cyc(); #1;
        tests++;
        if (bus.stall_d !== 1'b1) begin fails++; $display("FAIL stall_c2: got %b exp 1", bus.stall_d); end
        cyc(); #1;
        tests++;
        if (bus.stall_d !== 1'b0) begin fails++; $display("FAIL stall_c3: got %b exp 0", bus.stall_d); end
        cyc(); bus.inst_valid_d = 1'b0; #1;
        tests++;
        if ({bus.fwd_a, bus.fwd_b} !== 2'b00) begin fails++; $display("FAIL nofwd_ab: got %b exp 00", {bus.fwd_a, bus.fwd_b}); end
        cyc(); #1;
        tests++;
        if (bus.wb_rd !== 5'd2) begin fails++; $display("FAIL stall_accept_rd: got %0d exp 2", bus.wb_rd); end
`endif
    endtask

    task automatic test_x0();
        drain();
        cyc(); bus.inst_d = I_ADDI0; bus.inst_valid_d = 1'b1; #1;
        cyc(); bus.inst_d = I_ADD3; #1;
        tests++;
        if (bus.stall_d !== 1'b0) begin fails++; $display("FAIL x0_stall: got %b exp 0", bus.stall_d); end
        cyc(); bus.inst_valid_d = 1'b0; #1;
        tests++;
        if ({bus.fwd_a, bus.fwd_b} !== 2'b00) begin fails++; $display("FAIL x0_fwd: got %b exp 00", {bus.fwd_a, bus.fwd_b}); end
        cyc(); #1;
        tests++;
        if (bus.wb_rd !== 5'd3) begin fails++; $display("FAIL x0_accept_rd: got %0d exp 3", bus.wb_rd); end
    endtask

    task automatic test_branch();
        logic [63:0] i0;
        drain();
        cyc(); bus.inst_d = I_BEQ; bus.inst_valid_d = 1'b1; #1;
        cyc(); bus.inst_d = I_ADDI5; bus.br_eq = 1'b1; #1;
        tests++;
        if ({bus.pc_sel, bus.flush} !== 2'b11) begin fails++; $display("FAIL beq_taken: got %b exp 11", {bus.pc_sel, bus.flush}); end
        i0 = bus.instret_cnt;
        cyc(); bus.inst_valid_d = 1'b0; bus.br_eq = 1'b0; #1;
        tests++;
        if (bus.pc_sel !== 1'b0) begin fails++; $display("FAIL beq_one_cycle: got %b exp 0", bus.pc_sel); end
        cyc(); #1;
        tests++;
        if ({bus.reg_wen, bus.wb_rd} !== 6'd0) begin fails++; $display("FAIL flushed_w: got %b exp 0", {bus.reg_wen, bus.wb_rd}); end
        tests++;
        if (bus.instret_cnt !== i0 + 64'd1) begin fails++; $display("FAIL beq_instret: got %0d exp %0d", bus.instret_cnt, i0 + 64'd1); end
        cyc(); #1;
        tests++;
        if (bus.instret_cnt !== i0 + 64'd1) begin fails++; $display("FAIL flushed_instret: got %0d exp %0d", bus.instret_cnt, i0 + 64'd1); end
    endtask

    task automatic test_branch_cond();
        drain();
        cyc(); bus.inst_d = I_BNE; bus.inst_valid_d = 1'b1; #1;
        cyc(); bus.inst_d = I_BLTU; bus.br_eq = 1'b1; #1;
        tests++;
        if (bus.pc_sel !== 1'b0) begin fails++; $display("FAIL bne_not_taken: got %b exp 0", bus.pc_sel); end
        cyc(); bus.inst_valid_d = 1'b0; bus.br_eq = 1'b0; bus.br_lt = 1'b1; #1;
        tests++;
        if ({bus.br_un, bus.pc_sel} !== 2'b11) begin fails++; $display("FAIL bltu_taken: got %b exp 11", {bus.br_un, bus.pc_sel}); end
        bus.br_lt = 1'b0;
    endtask

    task automatic test_hold();
        logic [63:0] c0;
        logic [63:0] i0;
        drain();
        cyc(); bus.inst_d = I_ADDI5; bus.inst_valid_d = 1'b1; #1;
        cyc(); bus.inst_d = I_BEQ; #1;
        cyc(); bus.inst_valid_d = 1'b0; bus.br_eq = 1'b1; bus.hold = 1'b1; #1;
        tests++;
        if ({bus.pc_sel, bus.flush} !== 2'b00) begin fails++; $display("FAIL hold_pc_sel: got %b exp 00", {bus.pc_sel, bus.flush}); end
        c0 = bus.cycle_cnt;
        i0 = bus.instret_cnt;
        repeat (3) cyc();
        #1;
        tests++;
        if (bus.cycle_cnt !== c0 + 64'd3) begin fails++; $display("FAIL hold_cycle: got %0d exp %0d", bus.cycle_cnt, c0 + 64'd3); end
        tests++;
        if (bus.instret_cnt !== i0) begin fails++; $display("FAIL hold_instret: got %0d exp %0d", bus.instret_cnt, i0); end
        tests++;
        if ({bus.pc_sel, bus.reg_wen} !== 2'b01) begin fails++; $display("FAIL hold_frozen: got %b exp 01", {bus.pc_sel, bus.reg_wen}); end
        bus.hold = 1'b0; #1;
        tests++;
        if ({bus.pc_sel, bus.flush} !== 2'b11) begin fails++; $display("FAIL hold_release: got %b exp 11", {bus.pc_sel, bus.flush}); end
        cyc(); bus.br_eq = 1'b0; #1;
        tests++;
        if (bus.instret_cnt !== i0 + 64'd1) begin fails++; $display("FAIL release_instret: got %0d exp %0d", bus.instret_cnt, i0 + 64'd1); end
    endtask

    task automatic test_csr_jal();
        drain();
        cyc(); bus.inst_d = I_CSRRW; bus.inst_valid_d = 1'b1; #1;
        cyc(); bus.inst_d = I_JAL; #1;
        tests++;
        if (bus.imm_sel !== 3'd4) begin fails++; $display("FAIL jal_imm: got %0d exp 4", bus.imm_sel); end
        cyc(); bus.inst_valid_d = 1'b0; #1;
        tests++;
        if ({bus.csr_wen, bus.reg_wen, bus.wb_sel, bus.wb_rd} !== {1'b1, 1'b1, 2'd3, 5'd1}) begin
            fails++; $display("FAIL csr_w: got %b exp 1_1_11_00001", {bus.csr_wen, bus.reg_wen, bus.wb_sel, bus.wb_rd});
        end
        tests++;
        if ({bus.pc_sel, bus.a_sel, bus.b_sel} !== 3'b111) begin fails++; $display("FAIL jal_x: got %b exp 111", {bus.pc_sel, bus.a_sel, bus.b_sel}); end
        cyc(); #1;
        tests++;
        if ({bus.csr_wen, bus.wb_sel, bus.wb_rd} !== {1'b0, 2'd2, 5'd1}) begin
            fails++; $display("FAIL jal_w: got %b exp 0_10_00001", {bus.csr_wen, bus.wb_sel, bus.wb_rd});
        end
    endtask

    task automatic test_reset_mid();
        drain();
        cyc(); bus.inst_d = I_ADD; bus.inst_valid_d = 1'b1; #1;
        cyc(); bus.inst_d = I_SW; #1;
        cyc(); bus.inst_d = I_LUI; #1;
        tests++;
        if ({bus.imm_sel, bus.mem_wen, bus.reg_wen} !== {3'd3, 1'b1, 1'b1}) begin
            fails++; $display("FAIL pre_rst_busy: got %b exp 011_1_1", {bus.imm_sel, bus.mem_wen, bus.reg_wen});
        end
        rst = 1'b1; #1;
        tests++;
        if ({bus.imm_sel, bus.mem_wen, bus.mem_funct3, bus.b_sel, bus.reg_wen, bus.wb_rd, bus.wb_sel, bus.stall_d} !== 16'd0) begin
            fails++; $display("FAIL rst_mid_outs: got %b exp 0",
                {bus.imm_sel, bus.mem_wen, bus.mem_funct3, bus.b_sel, bus.reg_wen, bus.wb_rd, bus.wb_sel, bus.stall_d});
        end
        tests++;
        if ({bus.cycle_cnt, bus.instret_cnt} !== 128'd0) begin
            fails++; $display("FAIL rst_mid_cnt: got %0d/%0d exp 0/0", bus.cycle_cnt, bus.instret_cnt);
        end
        bus.inst_valid_d = 1'b0;
        cyc(); #1;
        tests++;
        if (bus.cycle_cnt !== 64'd0) begin fails++; $display("FAIL rst_mid_hold_cnt: got %0d exp 0", bus.cycle_cnt); end
        rst = 1'b0;
        cyc(); #1;
        tests++;
        if (bus.cycle_cnt !== 64'd1) begin fails++; $display("FAIL rst_mid_resume: got %0d exp 1", bus.cycle_cnt); end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_add();
        test_decode_table();
        test_raw_hazard();
        test_x0();
        test_branch();
        test_branch_cond();
        test_hold();
        test_csr_jal();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipelined control unit for the three-stage RV32I core (D: decode/fetch-out, X: execute/branch, W: memory-return/writeback). Decodes the instruction in D, carries the control bundle through stage registers into X and W, resolves branches and jumps in X, and generates PC redirect, flush, forwarding selects and data-hazard interlocks. It also keeps the cycle and instret counters. It replaces the single-cycle combinational decoder in the datapath.

## Interface
- `XLEN`, 32: datapath width; only sizes the counter readout mux.
- `CNT_W`, 64: width of the cycle and instret counters.
- `clk`  in  1  core clock.
- `rst`  in  1  reset: asynchronous, active-high.
- `inst_d`  in  32  instruction at D.
- `inst_valid_d`  in  1  `inst_d` holds a real instruction.
- `hold`  in  1  global freeze, for example while an I/O access waits.
- `br_eq`, `br_lt`  in  1 each  comparator results for the instruction in X.
- `imm_sel`  out  3  immediate type at D: I=0, S=1, B=2, U=3, J=4.
- `stall_d`  out  1  D instruction not accepted this cycle; fetch holds the PC.
- `a_sel`  out  1  X operand A: 0=rs1, 1=pc.
- `b_sel`  out  1  X operand B: 0=rs2, 1=imm.
- `alu_sel`  out  4  ALU op at X.
- `br_un`  out  1  X comparator is unsigned.
- `fwd_a`, `fwd_b`  out  1 each  X operand takes the W writeback value.
- `mem_wen`  out  1  store issues at X.
- `mem_funct3`  out  3  access size and sign at X.
- `pc_sel`  out  1  next PC = ALU result; redirect.
- `flush`  out  1  the D instruction is killed.
- `reg_wen`  out  1  register-file write at W.
- `wb_rd`  out  5  destination register at W.
- `wb_sel`  out  2  writeback source: 0=mem, 1=alu, 2=pc+4, 3=csr.
- `csr_wen`  out  1  CSR write at W.
- `cycle_cnt`, `instret_cnt`  out  CNT_W each  performance counters.

## Operation
- The D decode is combinational from `inst_d`. The bundle holds: valid, rd, rs1, rs2, all select fields, is_load, is_branch, is_jal, is_jalr, funct3.
- R-type ALU op:
  - funct3 000 gives SUB only when `inst[30]`=1; otherwise ADD.
  - funct3 101 gives SRA when `inst[30]`=1; otherwise SRL.
- I-type ALU op: never SUB. funct3 101 uses `inst[30]` the same way as R-type.
- Per-type operand selects:
  - LUI: A is forced to zero (operand A is zero-selected via ALU_BSEL).
  - AUIPC, JAL and branches: a_sel=pc.
  - JALR: a_sel=rs1.
  - Loads and stores: ADD.
- CSRRW and CSRRWI (funct3 001 or 101) set csr_wen. ECALL, EBREAK and all unknown opcodes decode to a bubble: valid=0 and every enable 0.
- Branch taken at X uses funct3: BEQ=eq, BNE=!eq, BLT/BGE=lt/!lt, BLTU/BGEU the same with br_un=1.
- Redirect: `pc_sel` = X.valid & (jal | jalr | branch taken). `flush` equals `pc_sel`.
- Forwarding (FWD_EN): `fwd_a` = W.valid & W.reg_wen & W.rd≠0 & W.rd==X.rs1. `fwd_b` is the same with rs2.
- Perf counters:
  - `cycle_cnt` increments every cycle.
  - `instret_cnt` increments on every edge where W.valid=1 and not `hold`.
  - Both wrap modulo 2^CNT_W.

## Timing
- X outputs come from the X register, valid the cycle after D accepts. W outputs come one cycle later.
- All X and W outputs are gated by their stage's valid bit, so a bubble drives 0.
- On each edge with `hold`=0:
  - X ← D bundle, or a bubble if `flush` | `stall_d` | !`inst_valid_d`.
  - W ← X.
- With `hold`=1:
  - No stage register changes.
  - `pc_sel`, `flush`, `mem_wen` and `stall_d` are forced 0, so a redirect is deferred until release.
- If `flush` and `stall_d` are both asserted, `flush` wins: the stalled instruction is wrong-path and is dropped.
- `rst` asserted at any time:
  - Both stages go to bubble immediately.
  - Every output goes to 0, including both counters.
  - Counting resumes on the first edge after release.

## Configuration
- `PIPE_CTRL_FWD_EN` defined:
  - Forwarding W→X is active.
  - `stall_d` is asserted only when `hold`=0 and nothing else applies, so it is effectively 0.
- `PIPE_CTRL_FWD_EN` undefined:
  - `fwd_a` and `fwd_b` are tied to 0.
  - `stall_d` = D.valid & (match(X) | match(W)). match(S) means S.valid & S.reg_wen & S.rd≠0 & S.rd ∈ {D.rs1 if used, D.rs2 if used}.
  - A dependent adjacent pair stalls 2 cycles.

## Structure
- `ctrl_pkg`:
  - ALU_* encodings: ADD=0, SUB=1, AND=2, OR=3, XOR=4, SLT=5, SLTU=6, SLL=7, SRL=8, SRA=9, BSEL=10.
  - IMM_*, WB_* and opcode constants.
  - The control-bundle struct.
- Sub-module `inst_decode`: purely combinational, inst → bundle. pipe_ctrl holds the stage registers, hazard logic, redirect logic and counters.

## Test plan
- `add x1,x2,x3` (0x003100B3) at D:
  - Next cycle: alu_sel=0, a_sel=0, b_sel=0.
  - Cycle after: reg_wen=1, wb_rd=1, wb_sel=1, instret +1.
- `addi x1,x0,5` then `add x2,x1,x1`:
  - With FWD_EN: fwd_a=fwd_b=1 when the add is in X, and no stall.
  - Without FWD_EN: stall_d=1 for exactly 2 cycles.
- `beq` with br_eq=1 in X:
  - pc_sel=flush=1 for one cycle.
  - The following instruction reaches W as a bubble: reg_wen=0, and instret does not increment for it.
- `addi x0,x0,1` followed by a dependent use of x0: fwd_a=0 and stall_d=0.
- hold=1 for 3 cycles with a taken branch in X:
  - pc_sel stays 0, cycle_cnt +3, instret +0.
  - On release, pc_sel=1 in the next cycle.
- rst pulsed mid-stream with an instruction in each stage: all outputs read 0 within the same cycle, and both counters read 0.
